// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the MIPS datapath.
// The opcode field bounds are the ones the Decoder uses on instr_op_i.
package if_pkg;

    localparam int          IF_ADDR_W   = 32;
    localparam int          IF_INSTR_W  = 32;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    localparam int OP_FIELD_HI = 31;
    localparam int OP_FIELD_LO = 26;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage : if_pkg

// File: rtl/instr_fetch_unit_if.sv
// Bundle of the instruction-memory and decode-side handshakes of the fetch stage.
// The master view belongs to the fetch unit; the slave view to memory, decode and redirect sources.
interface instr_fetch_unit_if
    import if_pkg::*;
#(
    parameter int ADDR_W  = IF_ADDR_W,
    parameter int INSTR_W = IF_INSTR_W
);

    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_ack_i;
    logic [INSTR_W-1:0] imem_rdata_i;

    logic               redirect_i;
    logic [ADDR_W-1:0]  redirect_pc_i;

    logic               instr_valid_o;
    logic               instr_ready_i;
    logic [INSTR_W-1:0] instr_o;
    logic [ADDR_W-1:0]  pc_o;
    logic [ADDR_W-1:0]  pc_plus4_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_ack_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output instr_valid_o, instr_o, pc_o, pc_plus4_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_ack_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  instr_valid_o, instr_o, pc_o, pc_plus4_o,
        output instr_ready_i
    );

endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit_out_reg.sv
// Holding register presenting one fetched instruction, its PC and PC+4 to decode.
// Load has priority over clear; with neither asserted the contents are held.
module if_out_reg
    import if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                INSTR_W  = IF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc,
    output logic [ADDR_W-1:0]  o_pc_plus4
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_pc_plus4;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc       <= RESET_PC;
            r_pc_plus4 <= RESET_PC + ADDR_W'(4);
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc + ADDR_W'(4);
        end else if (i_clear) begin
            r_valid    <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule : if_out_reg

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem request at a time, hands instructions to decode.
// Define IF_PERF_CNT_EN to add saturating fetch/flush counters on fetch_cnt_o/flush_cnt_o.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = IF_ADDR_W,
    parameter int                INSTR_W  = IF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_fetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        flush_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_REQ  = S_REQ;
    localparam logic [1:0] ST_HOLD = S_HOLD;

    logic [1:0]        r_state,   w_state_nxt;
    logic [ADDR_W-1:0] r_pc,      w_pc_nxt;
    logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
    logic              r_discard, w_discard_nxt;

    logic              w_out_load;
    logic              w_out_clear;
    logic              w_ack;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [ADDR_W-1:0] w_pc_plus4;

    assign w_ack         = bus.imem_ack_i;
    assign w_redirect    = bus.redirect_i;
    assign w_redirect_pc = {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign w_pc_plus4    = r_pc + ADDR_W'(4);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_addr_nxt    = r_addr;
        w_discard_nxt = r_discard;
        w_out_load    = 1'b0;
        w_out_clear   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_REQ;
                w_pc_nxt    = w_redirect ? w_redirect_pc : r_pc;
                w_addr_nxt  = w_redirect ? w_redirect_pc : r_pc;
            end

            ST_REQ: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_out_clear = 1'b1;
                    if (w_ack) begin
                        w_discard_nxt = 1'b0;
                        w_addr_nxt    = w_redirect_pc;
                    end else begin
                        // The outstanding request keeps its address; the reply is dropped later.
                        w_discard_nxt = 1'b1;
                    end
                end else if (w_ack) begin
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_addr_nxt    = r_pc;
                    end else begin
                        w_out_load  = 1'b1;
                        w_pc_nxt    = w_pc_plus4;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (w_redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_addr_nxt  = w_redirect_pc;
                    w_out_clear = 1'b1;
                    w_state_nxt = ST_REQ;
                end else if (bus.instr_ready_i) begin
                    w_addr_nxt  = r_pc;
                    w_out_clear = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_discard <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_addr    <= w_addr_nxt;
            r_discard <= w_discard_nxt;
        end
    end

    assign bus.imem_req_o  = (r_state == ST_REQ);
    assign bus.imem_addr_o = r_addr;

    if_out_reg #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) u_out_reg (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_out_load),
        .i_clear    (w_out_clear),
        .i_instr    (bus.imem_rdata_i),
        .i_pc       (r_pc),
        .o_valid    (bus.instr_valid_o),
        .o_instr    (bus.instr_o),
        .o_pc       (bus.pc_o),
        .o_pc_plus4 (bus.pc_plus4_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_accept;

    assign w_accept = bus.instr_valid_o & bus.instr_ready_i & ~w_redirect;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_accept && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o = r_fetch_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: normal fetch, back-pressure,
// redirects in each state, PC wrap-around and reset in the middle of a request.
module tb_instr_fetch_unit;
    import if_pkg::*;

    logic clk;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch_unit_if bus_if ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
`endif

    instr_fetch_unit dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if.master)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o (fetch_cnt),
        .flush_cnt_o (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) for a request, check its address is held for lat cycles, then ack it.
    task automatic fetch(input string tag, input logic [31:0] exp_addr, input int lat,
                         input logic [31:0] data);
        int n;
        n = 0;
        while (bus_if.imem_req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(bus_if.imem_req_o), 32'd1);
        chk({tag, "_addr"}, bus_if.imem_addr_o, exp_addr);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk({tag, "_addr_hold"}, bus_if.imem_addr_o, exp_addr);
        end
        bus_if.imem_ack_i   = 1'b1;
        bus_if.imem_rdata_i = data;
        tick();
        bus_if.imem_ack_i   = 1'b0;
        bus_if.imem_rdata_i = 32'h0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc, input logic [31:0] pc4);
        chk({tag, "_valid"}, 32'(bus_if.instr_valid_o), 32'd1);
        chk({tag, "_req_low"}, 32'(bus_if.imem_req_o), 32'd0);
        chk({tag, "_instr"}, bus_if.instr_o, instr);
        chk({tag, "_pc"}, bus_if.pc_o, pc);
        chk({tag, "_pc4"}, bus_if.pc_plus4_o, pc4);
    endtask

    task automatic accept(input string tag, input logic [31:0] next_addr);
        bus_if.instr_ready_i = 1'b1;
        tick();
        bus_if.instr_ready_i = 1'b0;
        chk({tag, "_valid_clr"}, 32'(bus_if.instr_valid_o), 32'd0);
        chk({tag, "_next_req"}, 32'(bus_if.imem_req_o), 32'd1);
        chk({tag, "_next_addr"}, bus_if.imem_addr_o, next_addr);
    endtask

    task automatic expect_reset(input string tag);
        chk({tag, "_req"}, 32'(bus_if.imem_req_o), 32'd0);
        chk({tag, "_addr"}, bus_if.imem_addr_o, 32'h0000_0000);
        chk({tag, "_valid"}, 32'(bus_if.instr_valid_o), 32'd0);
        chk({tag, "_instr"}, bus_if.instr_o, 32'h0000_0000);
        chk({tag, "_pc"}, bus_if.pc_o, 32'h0000_0000);
        chk({tag, "_pc4"}, bus_if.pc_plus4_o, 32'h0000_0004);
`ifdef IF_PERF_CNT_EN
        chk({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
        chk({tag, "_flush_cnt"}, flush_cnt, 32'd0);
`endif
    endtask

    initial begin
        logic [5:0] opcode;

        rst                  = 1'b1;
        bus_if.imem_ack_i    = 1'b0;
        bus_if.imem_rdata_i  = 32'h0;
        bus_if.redirect_i    = 1'b0;
        bus_if.redirect_pc_i = 32'h0;
        bus_if.instr_ready_i = 1'b0;

        // Reset state.
        repeat (2) tick();
        expect_reset("rst");
        rst = 1'b0;
        chk("idle_no_req", 32'(bus_if.imem_req_o), 32'd0);

        // Two sequential fetches, ack one cycle after each request.
        fetch("f0", 32'h0000_0000, 1, 32'h2002_0005);
        expect_out("f0", 32'h2002_0005, 32'h0000_0000, 32'h0000_0004);
        opcode = bus_if.instr_o[OP_FIELD_HI:OP_FIELD_LO];
        chk("f0_opcode", 32'(opcode), 32'h0000_0008);
        accept("f0", 32'h0000_0004);

        fetch("f4", 32'h0000_0004, 1, 32'h0000_0000);
        expect_out("f4", 32'h0000_0000, 32'h0000_0004, 32'h0000_0008);
        accept("f4", 32'h0000_0008);

        // Redirect to 0x40 while the request to 0x8 is outstanding.
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h0000_0040;
        tick();
        bus_if.redirect_i    = 1'b0;
        chk("rd_req_addr_kept", bus_if.imem_addr_o, 32'h0000_0008);
        chk("rd_req_still", 32'(bus_if.imem_req_o), 32'd1);
        chk("rd_no_valid", 32'(bus_if.instr_valid_o), 32'd0);
        tick();
        chk("rd_addr_kept_1", bus_if.imem_addr_o, 32'h0000_0008);
        tick();
        chk("rd_addr_kept_2", bus_if.imem_addr_o, 32'h0000_0008);
        bus_if.imem_ack_i   = 1'b1;
        bus_if.imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        bus_if.imem_ack_i   = 1'b0;
        bus_if.imem_rdata_i = 32'h0;
        chk("rd_discard_no_valid", 32'(bus_if.instr_valid_o), 32'd0);
        chk("rd_new_req", 32'(bus_if.imem_req_o), 32'd1);
        chk("rd_new_addr", bus_if.imem_addr_o, 32'h0000_0040);

        // Back-pressure: five cycles with ready low.
        fetch("f40", 32'h0000_0040, 1, 32'h8C22_0004);
        expect_out("f40", 32'h8C22_0004, 32'h0000_0040, 32'h0000_0044);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_instr", bus_if.instr_o, 32'h8C22_0004);
            chk("bp_pc", bus_if.pc_o, 32'h0000_0040);
            chk("bp_valid", 32'(bus_if.instr_valid_o), 32'd1);
            chk("bp_req_low", 32'(bus_if.imem_req_o), 32'd0);
        end
        accept("f40", 32'h0000_0044);

        // Redirect coinciding with the ack; unaligned target 0x13 becomes 0x10.
        bus_if.imem_ack_i    = 1'b1;
        bus_if.imem_rdata_i  = 32'hBAD0_0044;
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h0000_0013;
        tick();
        bus_if.imem_ack_i    = 1'b0;
        bus_if.imem_rdata_i  = 32'h0;
        bus_if.redirect_i    = 1'b0;
        chk("rdack_no_valid", 32'(bus_if.instr_valid_o), 32'd0);
        chk("rdack_req", 32'(bus_if.imem_req_o), 32'd1);
        chk("rdack_addr", bus_if.imem_addr_o, 32'h0000_0010);

        // Redirect and ready together while holding pc 0x10.
        fetch("f10", 32'h0000_0010, 1, 32'h1111_0010);
        expect_out("f10", 32'h1111_0010, 32'h0000_0010, 32'h0000_0014);
        bus_if.instr_ready_i = 1'b1;
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'h0000_0100;
        tick();
        bus_if.instr_ready_i = 1'b0;
        bus_if.redirect_i    = 1'b0;
        chk("rdhold_no_valid", 32'(bus_if.instr_valid_o), 32'd0);
        chk("rdhold_req", 32'(bus_if.imem_req_o), 32'd1);
        chk("rdhold_addr", bus_if.imem_addr_o, 32'h0000_0100);

        fetch("f100", 32'h0000_0100, 2, 32'h2222_0100);
        expect_out("f100", 32'h2222_0100, 32'h0000_0100, 32'h0000_0104);

        // Redirect in hold without ready, to the last word of the address space.
        bus_if.redirect_i    = 1'b1;
        bus_if.redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        bus_if.redirect_i    = 1'b0;
        chk("wrap_no_valid", 32'(bus_if.instr_valid_o), 32'd0);
        chk("wrap_req_addr", bus_if.imem_addr_o, 32'hFFFF_FFFC);

        fetch("ffc", 32'hFFFF_FFFC, 1, 32'h3333_FFFC);
        expect_out("ffc", 32'h3333_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
        accept("ffc", 32'h0000_0000);

        fetch("w0", 32'h0000_0000, 1, 32'h0800_0010);
        expect_out("w0", 32'h0800_0010, 32'h0000_0000, 32'h0000_0004);
        accept("w0", 32'h0000_0004);

        // Reset while the request to 0x4 is outstanding; ack arrives during reset.
        rst = 1'b1;
        #1;
        expect_reset("rst_mid");
        bus_if.imem_ack_i   = 1'b1;
        bus_if.imem_rdata_i = 32'h5555_AAAA;
        tick();
        tick();
        expect_reset("rst_ack");
        rst = 1'b0;
        tick();
        bus_if.imem_ack_i   = 1'b0;
        bus_if.imem_rdata_i = 32'h0;
        chk("post_rst_no_valid", 32'(bus_if.instr_valid_o), 32'd0);
        chk("post_rst_req", 32'(bus_if.imem_req_o), 32'd1);
        chk("post_rst_addr", bus_if.imem_addr_o, 32'h0000_0000);

        fetch("r0", 32'h0000_0000, 1, 32'hCAFE_0000);
        expect_out("r0", 32'hCAFE_0000, 32'h0000_0000, 32'h0000_0004);
        accept("r0", 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_instr_fetch_unit

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction Decoder in the CO project 3 MIPS datapath.
- Owns the PC register and issues requests to instruction memory over a req/ack handshake.
- Presents the fetched instruction, its PC and PC+4 to decode with a valid/ready handshake.
- Accepts branch/jump redirects; wrong-path fetches are dropped.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  ADDR_W  request address (byte address, word aligned).
- imem_ack_i  input  1  memory ack; imem_rdata_i valid in the same cycle.
- imem_rdata_i  input  INSTR_W  instruction read data.
- redirect_i  input  1  taken branch/jump from the downstream stage.
- redirect_pc_i  input  ADDR_W  redirect target.
- instr_valid_o  output  1  instr_o, pc_o and pc_plus4_o are valid.
- instr_ready_i  input  1  decode accepts this cycle.
- instr_o  output  INSTR_W  instruction; its [31:26] drives Decoder instr_op_i.
- pc_o  output  ADDR_W  PC of instr_o.
- pc_plus4_o  output  ADDR_W  pc_o + 4, modulo 2^ADDR_W.

Behaviour:
- Reset values (asynchronous, while rst_i=1):
  - PC = RESET_PC; state = S_IDLE.
  - imem_req_o = 0, imem_addr_o = RESET_PC.
  - instr_valid_o = 0, instr_o = 0, pc_o = RESET_PC, pc_plus4_o = RESET_PC+4.
  - discard flag = 0.
- S_IDLE: the first clock after reset is released moves to S_REQ.
- S_REQ:
  - imem_req_o = 1 and imem_addr_o = PC; both are held stable until imem_ack_i.
  - On ack with discard=0: latch instr_o = imem_rdata_i, pc_o = PC, pc_plus4_o = PC+4; set instr_valid_o; PC <= PC+4; go to S_HOLD.
  - On ack with discard=1: drop the data, clear discard, stay in S_REQ at the current PC.
- S_HOLD:
  - imem_req_o = 0 and instr_valid_o = 1.
  - Outputs are held stable while instr_ready_i=0.
  - On instr_ready_i=1: clear instr_valid_o and go to S_REQ the next cycle.
- Fetch latency: one instruction per (ack latency + 2) cycles minimum. No prefetch; at most one request outstanding.
- Redirect (redirect_i=1, sampled on the clock edge) has priority over every other event that cycle:
  - PC <= redirect_pc_i and instr_valid_o <= 0.
  - In S_REQ without ack that cycle: set discard=1. imem_addr_o stays on the old address until the pending ack arrives, because the handshake must not change an outstanding request.
  - In S_REQ with ack in the same cycle: drop the data, discard=0, stay in S_REQ at the new PC.
  - In S_HOLD: drop the held instruction and go to S_REQ.
  - In S_IDLE: PC is loaded and the block proceeds to S_REQ.
- Redirect and instr_ready_i in the same cycle: the redirect wins and the held instruction counts as consumed/flushed.
- Wrap-around: PC+4 from 32'hFFFF_FFFC gives 32'h0000_0000. No error is raised.
- redirect_pc_i[1:0] is forced to 0 (word alignment).
- Reset mid-request: all state is cleared immediately; any late imem_ack_i before the first S_REQ is ignored (S_IDLE ignores ack).

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, add outputs:
  - fetch_cnt_o (32): increments on every accepted instruction (instr_valid_o & instr_ready_i & !redirect_i).
  - flush_cnt_o (32): increments on every redirect_i cycle.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When not defined: these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package if_pkg:
  - state enum {S_IDLE, S_REQ, S_HOLD}
  - RESET_PC default
  - INSTR_W / ADDR_W constants
  - OP_FIELD_HI=31, OP_FIELD_LO=26 (shared with the Decoder)
- One sub-module, if_out_reg: the instr/pc/pc_plus4/valid holding register with load/clear/hold controls.
- The FSM and PC stay in the top level.

Test Plan:
- Reset, then ack 1 cycle after each req returning 32'h2002_0005, 32'h0000_0000: pc_o=0 then pc_o=4; pc_plus4_o=4 then 8; instr_valid_o pulses accepted with instr_ready_i=1.
- Hold instr_ready_i=0 for 5 cycles while valid: instr_o and pc_o stay constant and imem_req_o stays 0; accepted when ready=1, then the next req goes to addr+4.
- Redirect to 32'h0000_0040 while a request to 0x8 is outstanding (ack 3 cycles later): imem_addr_o stays 0x8 until ack; the data is discarded with no valid; the next req goes to 0x40.
- redirect_i and instr_ready_i together in S_HOLD at pc 0x10, target 0x100: no extra valid; the next fetch is from 0x100.
- Redirect to 32'hFFFF_FFFC: pc_plus4_o=0 after fetch; the next fetch address is 0x0.
- Assert rst_i mid-S_REQ with ack arriving during reset: all outputs return to reset values with no valid; fetch restarts at RESET_PC. With IF_PERF_CNT_EN, fetch_cnt_o=0 and flush_cnt_o=0 after reset.
